phys_regfile: RTL and testbench
===============================

# phys_regfile

Physical register storage for the out-of-order core. Holds DEPTH entries of WID bits with a per-entry ready bit, written by the writeback bus and marked pending by rename allocation. Sits directly upstream of the indexed read mux: its flattened data vector drives the mux's data input, and its ready vector tells issue logic which operands are valid.

## Interface
- WIDTH, 5, index bit width
- WID, 32, data bit width
- DEPTH, 1 << WIDTH, number of entries
- ZERO_ENTRY, 1, when 1, entry 0 is hardwired to zero and always ready

- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset; one clock, reset is synchronous and active-high
- alloc_en_i  input  1  rename allocates a destination entry
- alloc_idx_i  input  WIDTH  entry to mark pending
- wb_en_i  input  1  writeback valid
- wb_idx_i  input  WIDTH  entry to write
- wb_data_i  input  WID  value to write
- flush_i  input  1  pipeline squash
- data_o  output  WID*DEPTH  flattened entry data; entry i at bits [i*WID +: WID]
- ready_o  output  DEPTH  bit i = 1 when entry i holds a valid value
- pending_cnt_o  output  WIDTH+1  number of entries with ready = 0
- wb_ack_o  output  1  one-cycle acknowledge of a writeback

## Operation
- Reset (rst_i = 1 at an edge): all data 0, ready_o all 1, pending_cnt_o 0, wb_ack_o 0. Reset overrides every other input, including mid-operation.
- Allocation: alloc_en_i clears ready[alloc_idx_i]. Data is unchanged. Counter +1 only if the entry was ready.
- Writeback: wb_en_i writes wb_data_i to entry wb_idx_i and sets its ready bit.
  - Counter -1 only if the entry was pending.
  - A write to an already-ready entry updates the data; ready and the counter are unchanged.
- wb_ack_o: 1 in the cycle after any wb_en_i, including an ignored write to entry 0. Otherwise 0.
- Flush: sets all ready bits to 1 and forces the counter to 0. Data is not cleared.
  - An alloc in the same cycle is ignored.
  - A wb in the same cycle still writes its data.
- Alloc and wb in the same cycle:
  - Same index: data is written and ready ends 0. Alloc wins; the counter reflects the final state.
  - Different indices: both take effect; the net counter change is the sum.
- ZERO_ENTRY = 1: alloc and wb to index 0 are ignored for data and ready (the ack still fires). data_o[WID-1:0] is always 0, ready_o[0] is always 1, and the counter maximum is DEPTH-1.
- Invariant: pending_cnt_o always equals the count of zeros in ready_o.
- Out-of-range indices are impossible, because DEPTH = 1 << WIDTH.

## Timing
- All outputs are registered. An update at edge N is visible on data_o, ready_o and pending_cnt_o after edge N.
- No write-through: a mux read of wb_idx_i in the write cycle returns the old value.
- wb_ack_o rises exactly one cycle after wb_en_i and lasts one cycle per write. Back-to-back writes give back-to-back acks.
- No stall path: every alloc and wb is accepted in the cycle presented.

## Structure
- Shared package: default WIDTH, WID and DEPTH constants, common with the read mux and rename. No typedefs are required.
- One sub-module, ready_scoreboard. It holds the ready vector and pending counter, with inputs alloc, wb, flush and ZERO_ENTRY handling.
- The data array and wb_ack_o register live in phys_regfile.

## Test plan
- Reset, then idle: data_o = 0, ready_o = all ones, pending_cnt_o = 0, wb_ack_o = 0.
- Alloc idx 5, then wb idx 5 with 0xDEADBEEF the next cycle:
  - ready_o[5] goes 0, then 1.
  - pending_cnt_o goes 1, then 0.
  - data_o[5*32 +: 32] = 0xDEADBEEF.
  - wb_ack_o pulses one cycle after the wb.
- Same-cycle alloc and wb to idx 7 with 0x12345678: data = 0x12345678, ready_o[7] = 0, pending_cnt_o = 1.
- Alloc idx 1, 2 and 3, then flush_i together with alloc idx 4 and wb idx 9 = 0xAA: ready_o = all ones, pending_cnt_o = 0, entry 9 = 0xAA.
- Alloc idx 0 and wb idx 0 = 0xFFFFFFFF: entry 0 stays 0, ready_o[0] stays 1, counter stays 0, wb_ack_o still pulses.
- Assert rst_i in the middle of 3 pending allocs and a wb: the next cycle returns exactly to the reset values.

Source files
------------

// File: rtl/phys_regfile_pkg.sv
// phys_regfile_pkg: default geometry shared by the register file, read mux and rename
package phys_regfile_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_WID = 32;
  localparam int DEF_DEPTH = 1 << DEF_WIDTH;
endpackage

// File: rtl/phys_regfile_ready_scoreboard.sv
// ready_scoreboard: per-entry ready bits and pending-entry counter
module ready_scoreboard
  import phys_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 1 << WIDTH,
  parameter int ZERO_ENTRY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_en_i,
  input  logic [WIDTH-1:0] alloc_idx_i,
  input  logic             wb_en_i,
  input  logic [WIDTH-1:0] wb_idx_i,
  input  logic             flush_i,
  output logic [DEPTH-1:0] ready_o,
  output logic [WIDTH:0]   pending_cnt_o
);
  logic [DEPTH-1:0] rdy_n;
  logic [WIDTH:0]   cnt_n;
  // next ready vector: wb sets, flush sets all, alloc clears last so it wins on the same index
  always_comb begin
    rdy_n = ready_o;
    if (wb_en_i) rdy_n[wb_idx_i] = 1'b1;
    if (flush_i) rdy_n = '1;
    else if (alloc_en_i) rdy_n[alloc_idx_i] = 1'b0;
    if (ZERO_ENTRY != 0) rdy_n[0] = 1'b1;
    cnt_n = '0;
    for (int i = 0; i < DEPTH; i++) cnt_n = cnt_n + (WIDTH+1)'(!rdy_n[i]);
  end
  // counter is derived from the final ready state so it can never drift from it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o <= '1;
      pending_cnt_o <= '0;
    end else begin
      ready_o <= rdy_n;
      pending_cnt_o <= cnt_n;
    end
  end
endmodule

// File: rtl/phys_regfile.sv
// phys_regfile: physical register data array with ready scoreboard and writeback ack
module phys_regfile
  import phys_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WID = DEF_WID,
  parameter int DEPTH = 1 << WIDTH,
  parameter int ZERO_ENTRY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_en_i,
  input  logic [WIDTH-1:0]     alloc_idx_i,
  input  logic                 wb_en_i,
  input  logic [WIDTH-1:0]     wb_idx_i,
  input  logic [WID-1:0]       wb_data_i,
  input  logic                 flush_i,
  output logic [WID*DEPTH-1:0] data_o,
  output logic [DEPTH-1:0]     ready_o,
  output logic [WIDTH:0]       pending_cnt_o,
  output logic                 wb_ack_o
);
  logic [WID-1:0] mem [DEPTH];
  logic           wb_write;
  assign wb_write = wb_en_i && !(ZERO_ENTRY != 0 && wb_idx_i == '0);
  // data array: writeback stores regardless of flush; entry 0 stays zero when hardwired
  always_ff @(posedge clk_i) begin
    if (rst_i) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wb_write) mem[wb_idx_i] <= wb_data_i;
  end
  // ack every accepted writeback one cycle later, including ignored entry-0 writes
  always_ff @(posedge clk_i) begin
    wb_ack_o <= !rst_i && wb_en_i;
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign data_o[g*WID +: WID] = mem[g];
  end
  ready_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_ENTRY(ZERO_ENTRY)) u_sb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .alloc_en_i(alloc_en_i),
    .alloc_idx_i(alloc_idx_i),
    .wb_en_i(wb_en_i),
    .wb_idx_i(wb_idx_i),
    .flush_i(flush_i),
    .ready_o(ready_o),
    .pending_cnt_o(pending_cnt_o)
  );
endmodule

// File: tb/tb_phys_regfile.sv
// tb_phys_regfile: directed plus random stimulus against a behavioural register file model
module tb_phys_regfile;
  import phys_regfile_pkg::*;
  localparam int WIDTH = DEF_WIDTH;
  localparam int WID = DEF_WID;
  localparam int DEPTH = DEF_DEPTH;
  localparam int W = WID * DEPTH;
  logic                 clk = 1'b0;
  logic                 rst_i, alloc_en_i, wb_en_i, flush_i;
  logic [WIDTH-1:0]     alloc_idx_i, wb_idx_i;
  logic [WID-1:0]       wb_data_i;
  logic [W-1:0]         data_o;
  logic [DEPTH-1:0]     ready_o;
  logic [WIDTH:0]       pending_cnt_o;
  logic                 wb_ack_o;
  logic [WID-1:0]       m_data [DEPTH];
  bit                   m_rdy [DEPTH];
  int                   m_cnt;
  bit                   m_ack;
  bit                   m_ok = 1'b0;
  int                   vecs = 0;
  int                   errs = 0;

  phys_regfile #(.WIDTH(WIDTH), .WID(WID), .DEPTH(DEPTH), .ZERO_ENTRY(1)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .alloc_en_i(alloc_en_i),
    .alloc_idx_i(alloc_idx_i),
    .wb_en_i(wb_en_i),
    .wb_idx_i(wb_idx_i),
    .wb_data_i(wb_data_i),
    .flush_i(flush_i),
    .data_o(data_o),
    .ready_o(ready_o),
    .pending_cnt_o(pending_cnt_o),
    .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [W-1:0]     d;
    logic [DEPTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) begin
      d[i*WID +: WID] = m_data[i];
      r[i] = m_rdy[i];
    end
    check({ph, "data"}, data_o, d);
    check({ph, "ready"}, W'(ready_o), W'(r));
    check({ph, "cnt"}, W'(pending_cnt_o), W'(m_cnt));
    check({ph, "ack"}, W'(wb_ack_o), W'(m_ack));
  endtask

  task automatic model_step(input bit r, input bit ae, input int ai, input bit we, input int wi,
                            input logic [WID-1:0] wd, input bit fl);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_data[i] = '0;
        m_rdy[i] = 1'b1;
      end
      m_cnt = 0;
      m_ack = 1'b0;
      m_ok = 1'b1;
    end else begin
      if (we && wi != 0) begin
        m_data[wi] = wd;
        if (!m_rdy[wi]) m_cnt--;
        m_rdy[wi] = 1'b1;
      end
      if (fl) begin
        for (int i = 0; i < DEPTH; i++) m_rdy[i] = 1'b1;
        m_cnt = 0;
      end else if (ae && ai != 0) begin
        if (m_rdy[ai]) m_cnt++;
        m_rdy[ai] = 1'b0;
      end
      m_ack = we;
    end
  endtask

  task automatic cycle(input bit r, input bit ae, input int ai, input bit we, input int wi,
                       input logic [WID-1:0] wd, input bit fl);
    rst_i = r;
    alloc_en_i = ae;
    alloc_idx_i = WIDTH'(ai);
    wb_en_i = we;
    wb_idx_i = WIDTH'(wi);
    wb_data_i = wd;
    flush_i = fl;
    #1;
    if (m_ok) check_all("pre_");
    @(posedge clk);
    model_step(r, ae, ai, we, wi, wd, fl);
    #1;
    check_all("post_");
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, '0, 0);
    idle();
    check("rst_ready", W'(ready_o), W'({DEPTH{1'b1}}));
    check("rst_cnt", W'(pending_cnt_o), W'(0));
    check("rst_data", data_o, W'(0));
    check("rst_ack", W'(wb_ack_o), W'(0));
    cycle(0, 1, 5, 0, 0, '0, 0);
    check("a5_rdy", W'(ready_o[5]), W'(0));
    check("a5_cnt", W'(pending_cnt_o), W'(1));
    cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    check("w5_rdy", W'(ready_o[5]), W'(1));
    check("w5_cnt", W'(pending_cnt_o), W'(0));
    check("w5_data", W'(data_o[5*WID +: WID]), W'(32'hDEADBEEF));
    check("w5_ack", W'(wb_ack_o), W'(1));
    idle();
    check("w5_ack_end", W'(wb_ack_o), W'(0));
    cycle(0, 1, 7, 1, 7, 32'h12345678, 0);
    check("s7_data", W'(data_o[7*WID +: WID]), W'(32'h12345678));
    check("s7_rdy", W'(ready_o[7]), W'(0));
    check("s7_cnt", W'(pending_cnt_o), W'(1));
    cycle(0, 1, 1, 0, 0, '0, 0);
    cycle(0, 1, 2, 0, 0, '0, 0);
    cycle(0, 1, 3, 0, 0, '0, 0);
    check("pre_fl_cnt", W'(pending_cnt_o), W'(4));
    cycle(0, 1, 4, 1, 9, 32'hAA, 1);
    check("fl_ready", W'(ready_o), W'({DEPTH{1'b1}}));
    check("fl_cnt", W'(pending_cnt_o), W'(0));
    check("fl_e9", W'(data_o[9*WID +: WID]), W'(32'hAA));
    cycle(0, 1, 0, 1, 0, 32'hFFFFFFFF, 0);
    check("z_data", W'(data_o[WID-1:0]), W'(0));
    check("z_rdy", W'(ready_o[0]), W'(1));
    check("z_cnt", W'(pending_cnt_o), W'(0));
    check("z_ack", W'(wb_ack_o), W'(1));
    cycle(0, 1, 10, 0, 0, '0, 0);
    cycle(0, 1, 11, 0, 0, '0, 0);
    cycle(0, 1, 12, 1, 20, 32'h55, 0);
    cycle(1, 1, 13, 1, 10, 32'h77, 0);
    check("mr_ready", W'(ready_o), W'({DEPTH{1'b1}}));
    check("mr_cnt", W'(pending_cnt_o), W'(0));
    check("mr_data", data_o, W'(0));
    check("mr_ack", W'(wb_ack_o), W'(0));
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(63) == 0, $urandom_range(1) == 1, int'($urandom_range(DEPTH-1)),
            $urandom_range(1) == 1, int'($urandom_range(DEPTH-1)), $urandom,
            $urandom_range(15) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
